// File: rtl/ram_arb2_pkg.sv
// Shared defaults and encodings for the two-port RAM arbiter / clear sequencer.
package ram_arb2_pkg;

    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 32;
    localparam logic [DW_DEF-1:0] CLR_VAL_DEF = '0;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    typedef enum logic {
        PRI_A,
        PRI_B
    } pri_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; priority moves to the loser only when both request.
module rr_arb2
    import ram_arb2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    pri_t pri;
    logic conflict;

    always_comb begin
        conflict = en & req_a & req_b;
        gnt_a    = en & req_a & (~req_b | (pri == PRI_A));
        gnt_b    = en & req_b & (~req_a | (pri == PRI_B));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pri <= PRI_A;
        end else if (conflict) begin
            pri <= (pri == PRI_A) ? PRI_B : PRI_A;
        end
    end

endmodule

// File: rtl/ram_arb2.sv
// Arbiter and clear sequencer for a 1R/1W synchronous RAM shared by requesters A and B.
module ram_arb2
    import ram_arb2_pkg::*;
#(
    parameter int unsigned     AW      = AW_DEF,
    parameter int unsigned     DW      = DW_DEF,
    parameter logic [DW-1:0]   CLR_VAL = DW'(CLR_VAL_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          busy,
    input  logic          a_valid,
    input  logic          b_valid,
    output logic          a_ready,
    output logic          b_ready,
    input  logic          a_we,
    input  logic          b_we,
    input  logic [AW-1:0] a_addr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic [DW-1:0] b_wdata,
    output logic          a_rvalid,
    output logic          b_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rd,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wr,
    output logic          ram_we
);

    state_t        state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] raddr_q;
    logic          fwd_q;
    logic [DW-1:0] fwd_data_q;

    logic          run;
    logic          gnt_ra, gnt_rb, gnt_wa, gnt_wb;
    logic          rd_any, wr_any, fwd;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;

    assign run = (state == RUN);

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (run),
        .req_a (a_valid & ~a_we),
        .req_b (b_valid & ~b_we),
        .gnt_a (gnt_ra),
        .gnt_b (gnt_rb)
    );

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (run),
        .req_a (a_valid & a_we),
        .req_b (b_valid & b_we),
        .gnt_a (gnt_wa),
        .gnt_b (gnt_wb)
    );

    always_comb begin
        rd_any  = gnt_ra | gnt_rb;
        wr_any  = gnt_wa | gnt_wb;
        rd_addr = gnt_ra ? a_addr : b_addr;
        wr_addr = gnt_wa ? a_addr : b_addr;
        wr_data = gnt_wa ? a_wdata : b_wdata;
        // RAM reads the old word on a same-address collision, so bypass the write data.
        fwd     = rd_any & wr_any & (rd_addr == wr_addr);

        a_ready   = gnt_ra | gnt_wa;
        b_ready   = gnt_rb | gnt_wb;
        busy      = (state == CLEAR);
        ram_we    = ~run | wr_any;
        ram_waddr = run ? wr_addr : cnt;
        ram_wr    = run ? wr_data : CLR_VAL;
        ram_raddr = rd_any ? rd_addr : raddr_q;
        rdata     = fwd_q ? fwd_data_q : ((a_rvalid | b_rvalid) ? ram_rd : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= CLEAR;
            cnt        <= '0;
            raddr_q    <= '0;
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            a_rvalid <= gnt_ra;
            b_rvalid <= gnt_rb;
            fwd_q    <= fwd;
            if (fwd) begin
                fwd_data_q <= wr_data;
            end
            if (rd_any) begin
                raddr_q <= rd_addr;
            end
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arb2.sv
// Self-checking bench for ram_arb2: RAM macro model plus a behavioural arbitration/memory reference.
module tb_ram_arb2;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          busy;
    logic          a_valid, b_valid, a_ready, b_ready, a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_rvalid, b_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_raddr, ram_waddr;
    logic [DW-1:0] ram_rd, ram_wr;
    logic          ram_we;

    always #5 clk = ~clk;

    ram_arb2 #(.AW(AW), .DW(DW), .CLR_VAL('0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy),
        .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
        .a_we(a_we), .b_we(b_we), .a_addr(a_addr), .b_addr(b_addr),
        .a_wdata(a_wdata), .b_wdata(b_wdata), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .rdata(rdata), .ram_raddr(ram_raddr), .ram_rd(ram_rd), .ram_waddr(ram_waddr),
        .ram_wr(ram_wr), .ram_we(ram_we)
    );

    // RAM macro: read-before-write, one cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wr;
        ram_rd <= mem[ram_raddr];
    end

    int            nvec = 0;
    int            nerr = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_clear;
    int            m_cnt;
    bit            rd_pri, wr_pri;   // 0: A wins the next conflict
    logic [AW-1:0] last_raddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clear    = 1'b1;
        m_cnt      = 0;
        rd_pri     = 1'b0;
        wr_pri     = 1'b0;
        last_raddr = '0;
    endtask

    task automatic step(input bit av, input bit aw, input logic [7:0] aa, input logic [31:0] ad,
                        input bit bv, input bit bw, input logic [7:0] ba, input logic [31:0] bd,
                        input bit c);
        bit            ga_r, gb_r, ga_w, gb_w, any_r, any_w;
        logic [7:0]    ra, wa;
        logic [31:0]   wd, erd;
        a_valid = av; a_we = aw; a_addr = aa; a_wdata = ad;
        b_valid = bv; b_we = bw; b_addr = ba; b_wdata = bd;
        clr = c;
        #2;
        ga_r = 0; gb_r = 0; ga_w = 0; gb_w = 0;
        ra = '0; wa = '0; wd = '0; erd = '0;
        if (m_clear) begin
            chk("clr_busy", 32'(busy), 1);
            chk("clr_a_ready", 32'(a_ready), 0);
            chk("clr_b_ready", 32'(b_ready), 0);
            chk("clr_ram_we", 32'(ram_we), 1);
            chk("clr_waddr", 32'(ram_waddr), 32'(m_cnt));
            chk("clr_wdata", ram_wr, 0);
            chk("clr_raddr", 32'(ram_raddr), 32'(last_raddr));
            ref_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == DEPTH) m_clear = 1'b0;
        end else begin
            if (av && !aw && bv && !bw) begin
                ga_r = !rd_pri; gb_r = rd_pri; rd_pri = !rd_pri;
            end else begin
                ga_r = av && !aw; gb_r = bv && !bw;
            end
            if (av && aw && bv && bw) begin
                ga_w = !wr_pri; gb_w = wr_pri; wr_pri = !wr_pri;
            end else begin
                ga_w = av && aw; gb_w = bv && bw;
            end
            any_r = ga_r || gb_r;
            any_w = ga_w || gb_w;
            ra = ga_r ? aa : ba;
            wa = ga_w ? aa : ba;
            wd = ga_w ? ad : bd;
            chk("run_busy", 32'(busy), 0);
            chk("a_ready", 32'(a_ready), 32'(ga_r || ga_w));
            chk("b_ready", 32'(b_ready), 32'(gb_r || gb_w));
            chk("ram_we", 32'(ram_we), 32'(any_w));
            if (any_w) begin
                chk("ram_waddr", 32'(ram_waddr), 32'(wa));
                chk("ram_wr", ram_wr, wd);
            end
            chk("ram_raddr", 32'(ram_raddr), 32'(any_r ? ra : last_raddr));
            erd = (any_r && any_w && ra == wa) ? wd : ref_mem[ra];
            if (any_r) last_raddr = ra;
            if (any_w) ref_mem[wa] = wd;
            if (c) begin
                m_clear = 1'b1;
                m_cnt   = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("a_rvalid", 32'(a_rvalid), 32'(ga_r));
        chk("b_rvalid", 32'(b_rvalid), 32'(gb_r));
        if (ga_r || gb_r) chk("rdata", rdata, erd);
        @(negedge clk);
    endtask

    task automatic rstep(input logic [7:0] m);
        step($urandom_range(3) != 0, 1'($urandom_range(1)), 8'($urandom) & m, $urandom,
             $urandom_range(3) != 0, 1'($urandom_range(1)), 8'($urandom) & m, $urandom, 1'b0);
    endtask

    task automatic reset_checks();
        chk("rst_busy", 32'(busy), 1);
        chk("rst_ram_we", 32'(ram_we), 1);
        chk("rst_waddr", 32'(ram_waddr), 0);
        chk("rst_wr", ram_wr, 0);
        chk("rst_raddr", 32'(ram_raddr), 0);
        chk("rst_readys", 32'({a_ready, b_ready}), 0);
        chk("rst_rvalids", 32'({a_rvalid, b_rvalid}), 0);
        chk("rst_rdata", rdata, 0);
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0;
        a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        reset_checks();
        @(negedge clk);
        rst = 1'b1;

        // Power-up sweep with requests present; all must be refused.
        repeat (DEPTH) rstep(8'hFF);
        step(1, 0, 8'h7F, 0, 0, 0, 0, 0, 0);

        step(1, 0, 8'h10, 0, 1, 1, 8'h20, 32'hDEADBEEF, 0);
        step(0, 0, 0, 0, 1, 0, 8'h20, 0, 0);
        for (int i = 0; i < 4; i++)
            step(1, 0, 8'(i), 0, 1, 0, 8'(i + 8), 0, 0);
        step(1, 1, 8'h05, 32'h12345678, 1, 0, 8'h05, 0, 0);
        step(1, 1, 8'h06, 32'hCAFEF00D, 1, 1, 8'h07, 32'h0BADF00D, 0);
        step(1, 1, 8'h30, 32'h30303030, 0, 0, 0, 0, 0);

        repeat (300) rstep(8'h0F);
        repeat (100) rstep(8'hFF);

        // clr together with a read of 0x30, then clr ignored mid-sweep.
        step(1, 0, 8'h30, 0, 0, 0, 0, 0, 1);
        repeat (50) rstep(8'hFF);
        step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, 1);
        repeat (DEPTH - 51) rstep(8'hFF);
        repeat (100) rstep(8'h07);

        // Reset while a read response is pending.
        step(0, 0, 0, 0, 1, 0, 8'h03, 0, 0);
        rst = 1'b0;
        #1;
        chk("kill_b_rvalid", 32'(b_rvalid), 0);
        reset_checks();
        model_reset();
        a_valid = 0; b_valid = 0; clr = 0;
        @(negedge clk);
        rst = 1'b1;

        // Reset at sweep count 100 restarts the full sweep.
        repeat (100) rstep(8'hFF);
        rst = 1'b0;
        #1;
        reset_checks();
        model_reset();
        a_valid = 0; b_valid = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (DEPTH) rstep(8'hFF);
        repeat (60) rstep(8'h03);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
